// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch widths, reset PC default, PC step,
// fetch FSM state encoding and the instruction-buffer entry layout.
package cpu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INST_W  = 32;

    localparam logic [XLEN-1:0] RESET_PC_DFLT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // One buffered fetch: address in the upper half, instruction in the lower.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO with flush and a registered
// head (o_valid/o_data) that holds its last value when the buffer empties.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_push, i_data    write one entry
//   i_pop             consume head (ignored when empty)
//   i_flush           discard all entries (wins over push)
//   o_valid, o_data   registered head
//   o_count_c         current occupancy (combinational from pointers)
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wr_nxt;
    logic [PTR_W-1:0]  w_rd_nxt;
    logic [PTR_W-1:0]  w_cnt_nxt;
    logic              w_valid_nxt;
    logic [DATA_W-1:0] w_data_nxt;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                     (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    // Next pointers and next registered head.
    always_comb begin
        w_wr_nxt    = r_wr_ptr + PTR_W'(w_push);
        w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);
        w_cnt_nxt   = w_wr_nxt - w_rd_nxt;
        w_valid_nxt = (w_cnt_nxt != '0);
        w_data_nxt  = r_data;
        if (w_valid_nxt) begin
            // A single remaining entry that is being written now bypasses the array.
            if (w_push && (w_cnt_nxt == PTR_W'(1))) begin
                w_data_nxt = i_data;
            end else begin
                w_data_nxt = r_mem[w_rd_nxt[IDX_W-1:0]];
            end
        end
        if (i_flush) begin
            w_wr_nxt    = '0;
            w_rd_nxt    = '0;
            w_valid_nxt = 1'b0;
            w_data_nxt  = r_data;
        end
    end

    // Pointer and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_valid  <= w_valid_nxt;
            r_data   <= w_data_nxt;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= i_data;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_count_c = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues sequential word fetches over a req/ack
// memory handshake (one outstanding), buffers returned instructions and hands
// them to decode over valid/ready. Redirects flush the buffer and drain any
// in-flight request before fetching from the new target.
// Ports:
//   clk, rst                    clock, async active-low reset
//   imem_req/addr/ack/rdata     instruction memory handshake
//   redirect_valid/pc           one-cycle restart request
//   if_valid/ready/inst/pc      decode interface (buffer head)
//   pc                          next address to be fetched
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DFLT,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] pc
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned CW1   = CNT_W + 1;

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_addr;
    logic [31:0]  w_addr_nxt;
    logic         r_req;
    logic         w_req_nxt;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic [CW1-1:0]   w_cnt_base;
    logic             w_room_idle;
    logic             w_room_push;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;
    logic             w_head_valid;

    assign w_pop        = w_head_valid && if_ready;
    assign w_push_entry = '{pc: r_addr, inst: imem_rdata};

    // Credit: occupancy after this cycle's pop, plus the request about to issue,
    // must stay within the buffer.
    assign w_cnt_base  = CW1'(w_count) - CW1'(w_pop);
    assign w_room_idle = (w_cnt_base < CW1'(BUF_DEPTH));
    assign w_room_push = ((w_cnt_base + CW1'(1)) < CW1'(BUF_DEPTH));

    inst_fifo #(
        .DEPTH  (BUF_DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .i_push    (w_push),
        .i_data    (w_push_entry),
        .i_pop     (w_pop),
        .i_flush   (redirect_valid),
        .o_valid   (w_head_valid),
        .o_data    (w_head),
        .o_count_c (w_count)
    );

    // Fetch FSM next-state, pc and request address.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!redirect_valid && w_room_idle) begin
                    w_state_nxt = REQ;
                    w_addr_nxt  = r_pc;
                end
            end
            REQ: begin
                if (imem_ack && !redirect_valid) begin
                    w_push   = 1'b1;
                    w_pc_nxt = r_pc + PC_STEP;
                    if (w_room_push) begin
                        w_addr_nxt = r_pc + PC_STEP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (redirect_valid && !imem_ack) begin
                    w_state_nxt = DRAIN;
                end else if (redirect_valid) begin
                    // Acked data belongs to the old path; drop it.
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (redirect_valid) begin
            w_pc_nxt = align_word(redirect_pc);
        end
        w_req_nxt = (w_state_nxt != IDLE);
    end

    // State, pc and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_req   <= w_req_nxt;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign pc        = r_pc;
    assign if_valid  = w_head_valid;
    assign if_inst   = w_head.inst;
    assign if_pc     = w_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a memory model with selectable ack
// latency, a scoreboard of expected {pc, inst} entries filled on accepted acks
// and drained on decode pops, plus directed checks for each scenario.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] pc;

    // Second instance with a reset PC near the top of the address space.
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] inst2;
    logic [31:0] ifpc2;
    logic [31:0] pc2;

    int unsigned mem_lat;
    int unsigned r_wait;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: ack once the request has waited mem_lat cycles.
    assign imem_ack   = imem_req && (r_wait >= mem_lat);
    assign imem_rdata = word_at(imem_addr);
    always @(posedge clk or negedge rst) begin
        if (!rst) r_wait <= 0;
        else if (imem_req && !imem_ack) r_wait <= r_wait + 1;
        else r_wait <= 0;
    end

    assign ack2   = req2;
    assign rdata2 = word_at(addr2);

    inst_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .pc             (pc)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) u_dut_hi (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_ack       (ack2),
        .imem_rdata     (rdata2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (valid2),
        .if_ready       (1'b1),
        .if_inst        (inst2),
        .if_pc          (ifpc2),
        .pc             (pc2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    logic [63:0] sb_q[$];
    logic [63:0] sb_e;
    logic        drain_pending;
    int unsigned n_acks;
    logic [31:0] last_ack_addr;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;

    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
            drain_pending = 1'b0;
            n_acks        = 0;
            last_ack_addr = '0;
            prev_req      = 1'b0;
            prev_ack      = 1'b0;
            prev_addr     = '0;
        end else begin
            if (prev_req && !prev_ack) begin
                chk("req_hold", 32'(imem_req), 32'd1);
                chk("addr_hold", imem_addr, prev_addr);
            end
            if (if_valid && if_ready) begin
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    sb_e = sb_q.pop_front();
                    chk("if_pc", if_pc, sb_e[63:32]);
                    chk("if_inst", if_inst, sb_e[31:0]);
                end
            end
            if (imem_ack) begin
                n_acks++;
                last_ack_addr = imem_addr;
                if (!redirect_valid && !drain_pending)
                    sb_q.push_back({imem_addr, word_at(imem_addr)});
            end
            if (redirect_valid) begin
                sb_q.delete();
                drain_pending = imem_req && !imem_ack;
            end else if (imem_ack) begin
                drain_pending = 1'b0;
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    task automatic start(input int unsigned lat, input logic rdy);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_lat        = lat;
        if_ready       = rdy;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic wait_req(input logic [31:0] a, input string tag);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < 60) begin
            cyc();
            n++;
        end
        chk(tag, imem_req ? imem_addr : 32'hDEAD_DEAD, a);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        int n = 0;
        while (!if_valid && n < 60) begin
            cyc();
            n++;
        end
        chk(tag, if_valid ? if_pc : 32'hDEAD_DEAD, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        mem_lat        = 0;
        #1 rst = 1'b0;
        cyc();
        cyc();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_ifpc", if_pc, 32'h0);
        chk("rst_pc_hi", pc2, 32'hFFFF_FFF8);
        chk("rst_addr_hi", addr2, 32'hFFFF_FFF8);

        // Zero-wait sequential fetch; high-reset instance checks wraparound.
        start(0, 1'b1);
        cyc();
        chk("t1_addr0", imem_req ? imem_addr : 32'hDEAD_DEAD, 32'h0);
        chk("t6_addr0", req2 ? addr2 : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
        cyc();
        chk("t1_addr1", imem_addr, 32'h4);
        chk("t1_ifpc0", if_valid ? if_pc : 32'hDEAD_DEAD, 32'h0);
        chk("t6_addr1", addr2, 32'hFFFF_FFFC);
        chk("t6_ifpc0", valid2 ? ifpc2 : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
        chk("t6_inst0", inst2, word_at(32'hFFFF_FFF8));
        cyc();
        chk("t1_addr2", imem_addr, 32'h8);
        chk("t1_ifpc1", if_pc, 32'h4);
        chk("t6_addr2", addr2, 32'h0);
        chk("t6_ifpc1", ifpc2, 32'hFFFF_FFFC);
        cyc();
        chk("t1_ifpc2", if_pc, 32'h8);
        chk("t1_pc", pc, 32'hC);
        chk("t6_ifpc2", ifpc2, 32'h0);

        // Decode stalled: buffer fills, then one pop admits exactly one fetch.
        start(0, 1'b0);
        repeat (10) cyc();
        chk("t2_acks", n_acks, 32'd4);
        chk("t2_last", last_ack_addr, 32'hC);
        chk("t2_req", 32'(imem_req), 32'd0);
        chk("t2_pc", pc, 32'h10);
        chk("t2_head", if_valid ? if_pc : 32'hDEAD_DEAD, 32'h0);
        if_ready = 1'b1;
        cyc();
        if_ready = 1'b0;
        repeat (6) cyc();
        chk("t2_acks2", n_acks, 32'd5);
        chk("t2_last2", last_ack_addr, 32'h10);
        chk("t2_req2", 32'(imem_req), 32'd0);
        chk("t2_pc2", pc, 32'h14);
        chk("t2_head2", if_pc, 32'h4);

        // Slow memory: requests held, one at a time, one fetch per 4 cycles.
        start(3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t3_hold", imem_req ? imem_addr : 32'hDEAD_DEAD, 32'h0);
            chk("t3_pc", pc, 32'h0);
        end
        c = 3;
        do begin
            cyc();
            c++;
            @(negedge clk);
            #1;
        end while (n_acks < 4 && c < 60);
        chk("t3_cycles", c, 32'd16);
        cyc();
        chk("t3_pc4", pc, 32'h10);
        chk("t3_addr4", imem_addr, 32'h10);

        // Redirect while a request is outstanding.
        start(3, 1'b1);
        wait_req(32'h8, "t4_req8");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        cyc();
        redirect_valid = 1'b0;
        chk("t4_flush", 32'(if_valid), 32'd0);
        chk("t4_pc", pc, 32'h100);
        chk("t4_drain_req", 32'(imem_req), 32'd1);
        chk("t4_drain_addr", imem_addr, 32'h8);
        n = 0;
        while (!(imem_req && imem_addr != 32'h8) && n < 60) begin
            cyc();
            n++;
        end
        chk("t4_next_addr", imem_req ? imem_addr : 32'hDEAD_DEAD, 32'h100);
        wait_valid("t4_first_ifpc", 32'h100);
        chk("t4_first_inst", if_inst, word_at(32'h100));

        // Redirect in the same cycle as an ack.
        start(0, 1'b1);
        wait_req(32'h8, "t5_req8");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        chk("t5_flush", 32'(if_valid), 32'd0);
        chk("t5_idle", 32'(imem_req), 32'd0);
        chk("t5_pc", pc, 32'h200);
        cyc();
        chk("t5_next_addr", imem_req ? imem_addr : 32'hDEAD_DEAD, 32'h200);
        wait_valid("t5_first_ifpc", 32'h200);
        chk("t5_first_inst", if_inst, word_at(32'h200));

        // Asynchronous reset in the middle of a request.
        start(3, 1'b0);
        n = 0;
        while (!(if_valid && imem_req) && n < 40) begin
            cyc();
            n++;
        end
        chk("t6_pre", 32'(if_valid && imem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_req", 32'(imem_req), 32'd0);
        chk("t6_async_valid", 32'(if_valid), 32'd0);
        chk("t6_async_pc", pc, 32'h0);
        chk("t6_async_addr", imem_addr, 32'h0);
        chk("t6_async_ifpc", if_pc, 32'h0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
